cla_add_pipe: RTL and testbench
===============================

CLA_ADD_PIPE -- requirements
Module: cla_add_pipe

Interface
REQ-001 Parameter WIDTH, default 16, operand width; SHALL be a multiple of 4 in range 4..32; other values are illegal (elaboration error).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  operand beat offered.
REQ-005 in_ready  output  1  block accepts operand beat this cycle.
REQ-006 a  input  WIDTH  operand A (unsigned / two's complement).
REQ-007 b  input  WIDTH  operand B.
REQ-008 cin  input  1  carry-in.
REQ-009 out_valid  output  1  result beat present.
REQ-010 out_ready  input  1  downstream accepts result beat.
REQ-011 sum  output  WIDTH  a+b+cin, low WIDTH bits.
REQ-012 cout  output  1  carry out of bit WIDTH-1.
REQ-013 ovf  output  1  signed overflow; present only when CLA_ADD_OVF_EN is defined (REQ-031).

Function
REQ-014 Input transfer occurs when in_valid && in_ready; output transfer occurs when out_valid && out_ready.
REQ-015 Pipeline is two register stages, S1 and S2; global advance enable adv = !out_valid || out_ready.
REQ-016 in_ready SHALL equal adv, combinationally; no dependence on in_valid.
REQ-017 S1 (on adv): per 4-bit group i, register g=a&b, p=a|b, half-sum h=a^b, group generate G_i and group propagate P_i (4-bit lookahead), cin, and valid bit v1 <= in_valid.
REQ-018 G_i/P_i SHALL use full 4-bit lookahead: G=g3|p3g2|p3p2g1|p3p2p1g0, P=p3&p2&p1&p0.
REQ-019 S2 (on adv): compute group carries C_0=cin, C_(i+1)=G_i|(P_i&C_i) across groups; intra-group carries from registered g/p and C_i; register sum=h^carries, cout=C_(WIDTH/4), v2 <= v1.
REQ-020 out_valid SHALL equal v2; sum/cout/ovf are the S2 registers.
REQ-021 Latency: result of a beat accepted at edge N is valid after edge N+2 when adv held high; throughput one beat per cycle.
REQ-022 Stall: when adv=0, S1 and S2 (data and valid) hold unchanged; sum/cout/ovf stable while out_valid && !out_ready.
REQ-023 Bubbles are not collapsed: an empty S1 advances into S2 like a full one.
REQ-024 Register data in S1/S2 may update with invalid beats; only valid-qualified values are meaningful.
REQ-025 Arithmetic is modulo 2^WIDTH; cout is the true carry; a=all-ones, b=0, cin=1 yields sum=0, cout=1.
REQ-026 Ordering: results SHALL leave in exact acceptance order; no beat dropped or duplicated.

Reset
REQ-027 On rst=1 at a rising edge: v1=0, v2=0, sum=0, cout=0, ovf=0 (if present).
REQ-028 Reset mid-operation discards all in-flight beats; out_valid=0 from the cycle after the reset edge.
REQ-029 in_ready SHALL be 1 during and after reset (adv=1 because out_valid=0); beats offered while rst=1 are discarded.
REQ-030 rst has priority over adv.

Configuration
REQ-031 Macro CLA_ADD_OVF_EN: when defined, port ovf exists and is registered in S2 as carry-into-MSB XOR cout, reset 0, held on stall; when undefined, ovf port and logic are absent and all other behaviour is identical.

Verification
REQ-032 WIDTH=16, out_ready=1: a=0x00FF, b=0x0001, cin=0 at edge 0 -> out_valid=1 after edge 2, sum=0x0100, cout=0.
REQ-033 a=0xFFFF, b=0x0000, cin=1 (full ripple through all groups) -> sum=0x0000, cout=1; with OVF_EN ovf=0.
REQ-034 With OVF_EN: a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1; a=0x8000, b=0x8000 -> sum=0x0000, cout=1, ovf=1.
REQ-035 Back-to-back 4 beats (1+1, 2+2, 3+3, 4+4), out_ready low 3 cycles after first result -> in_ready=0 during stall, sum=0x0002 held, then 0x0004, 0x0006, 0x0008 in order, none lost.
REQ-036 Two beats in flight, rst=1 one cycle -> out_valid=0 next cycle, no stale result emitted afterwards; next accepted beat 5+6 -> sum=0x000B after 2 cycles.
REQ-037 Random a/b/cin, random in_valid/out_ready, WIDTH=4,16,32 -> every result equals reference {cout,sum}=a+b+cin, in order.

Source files
------------

// File: rtl/cla_add_pipe.sv
// Two-stage pipelined carry-lookahead adder with valid/ready handshake.
// Optional signed-overflow output is enabled by defining CLA_ADD_OVF_EN.
module cla_add_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CLA_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NG = WIDTH / 4;

  generate
    if (WIDTH < 4 || WIDTH > 32 || (WIDTH % 4) != 0) begin : g_bad_width
      $error("cla_add_pipe: WIDTH must be a multiple of 4 in the range 4..32");
    end
  endgenerate

  logic             adv;
  logic             v1_reg, v2_reg;
  logic [WIDTH-1:0] g_reg, p_reg, h_reg;
  logic [NG-1:0]    grp_g_reg, grp_p_reg;
  logic             cin_reg;
  logic [WIDTH-1:0] g_next, p_next, h_next;
  logic [NG-1:0]    grp_g_next, grp_p_next;
  logic [NG:0]      grp_c;
  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] sum_reg, sum_next;
  logic             cout_reg;

  // Whole pipeline moves together; a bubble in S2 never blocks upstream.
  assign adv      = !v2_reg || out_ready;
  assign in_ready = adv;

  assign g_next = a & b;
  assign p_next = a | b;
  assign h_next = a ^ b;

  genvar gi;
  generate
    for (gi = 0; gi < NG; gi++) begin : g_grp
      localparam int B = 4 * gi;

      assign grp_g_next[gi] = g_next[B+3]
                            | (p_next[B+3] & g_next[B+2])
                            | (p_next[B+3] & p_next[B+2] & g_next[B+1])
                            | (p_next[B+3] & p_next[B+2] & p_next[B+1] & g_next[B]);
      assign grp_p_next[gi] = &p_next[B+3:B];

      // Intra-group carries from the registered bit terms and this group's carry-in
      assign carry[B]   = grp_c[gi];
      assign carry[B+1] = g_reg[B] | (p_reg[B] & grp_c[gi]);
      assign carry[B+2] = g_reg[B+1]
                        | (p_reg[B+1] & g_reg[B])
                        | (p_reg[B+1] & p_reg[B] & grp_c[gi]);
      assign carry[B+3] = g_reg[B+2]
                        | (p_reg[B+2] & g_reg[B+1])
                        | (p_reg[B+2] & p_reg[B+1] & g_reg[B])
                        | (p_reg[B+2] & p_reg[B+1] & p_reg[B] & grp_c[gi]);
    end
  endgenerate

  always_comb begin
    grp_c    = '0;
    grp_c[0] = cin_reg;
    for (int i = 0; i < NG; i++) begin
      grp_c[i+1] = grp_g_reg[i] | (grp_p_reg[i] & grp_c[i]);
    end
  end

  assign sum_next = h_reg ^ carry;

  // S1 data carries no meaning without v1, so it needs no reset
  always_ff @(posedge clk) begin
    if (adv) begin
      g_reg     <= g_next;
      p_reg     <= p_next;
      h_reg     <= h_next;
      grp_g_reg <= grp_g_next;
      grp_p_reg <= grp_p_next;
      cin_reg   <= cin;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_reg   <= 1'b0;
      v2_reg   <= 1'b0;
      sum_reg  <= '0;
      cout_reg <= 1'b0;
    end else if (adv) begin
      v1_reg   <= in_valid;
      v2_reg   <= v1_reg;
      sum_reg  <= sum_next;
      cout_reg <= grp_c[NG];
    end
  end

`ifdef CLA_ADD_OVF_EN
  logic ovf_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_reg <= 1'b0;
    end else if (adv) begin
      ovf_reg <= carry[WIDTH-1] ^ grp_c[NG];
    end
  end

  assign ovf = ovf_reg;
`endif

  assign out_valid = v2_reg;
  assign sum       = sum_reg;
  assign cout      = cout_reg;

endmodule

// File: tb/tb_cla_add_pipe.sv
// Self-checking bench for cla_add_pipe: WIDTH=4/16/32 instances share one handshake,
// checked against an arithmetic reference model and an in-order scoreboard.
module tb_cla_add_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] a32, b32;
  logic        cin;

  logic        in_ready4, in_ready16, in_ready32;
  logic        out_valid4, out_valid16, out_valid32;
  logic [3:0]  sum4;
  logic [15:0] sum16;
  logic [31:0] sum32;
  logic        cout4, cout16, cout32;
`ifdef CLA_ADD_OVF_EN
  logic        ovf4, ovf16, ovf32;
`endif

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
  } beat_t;

  beat_t q[$];
  int    n_chk  = 0;
  int    n_pass = 0;
  int    n_fail = 0;
  int    pop_cnt = 0;
  int    p0;

  cla_add_pipe #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .a(a32[3:0]), .b(b32[3:0]), .cin(cin), .out_valid(out_valid4),
    .out_ready(out_ready), .sum(sum4), .cout(cout4)
`ifdef CLA_ADD_OVF_EN
    , .ovf(ovf4)
`endif
  );

  cla_add_pipe #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready16),
    .a(a32[15:0]), .b(b32[15:0]), .cin(cin), .out_valid(out_valid16),
    .out_ready(out_ready), .sum(sum16), .cout(cout16)
`ifdef CLA_ADD_OVF_EN
    , .ovf(ovf16)
`endif
  );

  cla_add_pipe #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32),
    .a(a32), .b(b32), .cin(cin), .out_valid(out_valid32),
    .out_ready(out_ready), .sum(sum32), .cout(cout32)
`ifdef CLA_ADD_OVF_EN
    , .ovf(ovf32)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation time limit exceeded");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: {cout,sum} = a + b + cin computed in wide arithmetic, truncated to w+1 bits
  function automatic logic [63:0] ref_add(input beat_t t, input int w);
    logic [63:0] m, r;
    m = (64'd1 << w) - 64'd1;
    r = ({32'b0, t.a} & m) + ({32'b0, t.b} & m) + {63'b0, t.cin};
    return r & ((m << 1) | 64'd1);
  endfunction

  function automatic logic [63:0] ref_ovf(input beat_t t, input int w);
    logic [63:0] r;
    logic        am, bm, sm;
    r  = ref_add(t, w);
    am = t.a[w-1];
    bm = t.b[w-1];
    sm = r[w-1];
    return {63'b0, (am == bm) && (sm != am)};
  endfunction

  task automatic drive(input logic v, input logic [31:0] av, input logic [31:0] bv, input logic c);
    in_valid = v;
    a32      = av;
    b32      = bv;
    cin      = c;
  endtask

  // One clock: scoreboard transfers evaluated at negedge, then return 1 unit after posedge
  task automatic tick();
    beat_t e;
    @(negedge clk);
    if (rst) begin
      q.delete();
    end else begin
      if (out_valid16 && out_ready) begin
        if (q.size() == 0) begin
          chk("spurious_out", {63'b0, out_valid16}, 64'd0);
        end else begin
          e = q.pop_front();
          pop_cnt++;
          chk("res_w4",  64'({cout4, sum4}),   ref_add(e, 4));
          chk("res_w16", 64'({cout16, sum16}), ref_add(e, 16));
          chk("res_w32", 64'({cout32, sum32}), ref_add(e, 32));
`ifdef CLA_ADD_OVF_EN
          chk("ovf_w4",  64'(ovf4),  ref_ovf(e, 4));
          chk("ovf_w16", 64'(ovf16), ref_ovf(e, 16));
          chk("ovf_w32", 64'(ovf32), ref_ovf(e, 32));
`endif
          $display("out #%0d a=%08h b=%08h cin=%0d sum16=%04h cout16=%0d sum32=%08h cout32=%0d",
                   pop_cnt, e.a, e.b, e.cin, sum16, cout16, sum32, cout32);
        end
      end
      if (in_valid && in_ready16) q.push_back(beat_t'{a32, b32, cin});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    out_ready = 1'b0;
    drive(1'b1, 32'h1234, 32'h4321, 1'b0);
    @(posedge clk);
    #1;
    tick();
    tick();
    chk("rst_out_valid", 64'(out_valid16), 64'd0);
    chk("rst_sum",       64'(sum16),       64'd0);
    chk("rst_cout",      64'(cout16),      64'd0);
    chk("rst_in_ready",  64'(in_ready16),  64'd1);
    rst = 1'b0;
    out_ready = 1'b1;

    // 0x00FF + 0x0001: visible two edges after being offered
    drive(1'b1, 32'h00FF, 32'h0001, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    chk("lat_edge1_valid", 64'(out_valid16), 64'd0);
    tick();
    chk("lat_edge2_valid", 64'(out_valid16), 64'd1);
    chk("lat_sum",         64'(sum16),       64'h0100);
    chk("lat_cout",        64'(cout16),      64'd0);

    // Full ripple through every group
    drive(1'b1, 32'hFFFF, 32'h0000, 1'b1);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    chk("ripple_sum",  64'(sum16),  64'h0000);
    chk("ripple_cout", 64'(cout16), 64'd1);
`ifdef CLA_ADD_OVF_EN
    chk("ripple_ovf",  64'(ovf16),  64'd0);
`endif

    // Signed-overflow corners, back to back
    drive(1'b1, 32'h7FFF, 32'h0001, 1'b0);
    tick();
    drive(1'b1, 32'h8000, 32'h8000, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    chk("pos_ovf_sum",  64'(sum16),  64'h8000);
    chk("pos_ovf_cout", 64'(cout16), 64'd0);
`ifdef CLA_ADD_OVF_EN
    chk("pos_ovf_flag", 64'(ovf16),  64'd1);
`endif
    tick();
    chk("neg_ovf_sum",  64'(sum16),  64'h0000);
    chk("neg_ovf_cout", 64'(cout16), 64'd1);
`ifdef CLA_ADD_OVF_EN
    chk("neg_ovf_flag", 64'(ovf16),  64'd1);
`endif
    repeat (2) tick();

    // Back-to-back beats with a 3-cycle downstream stall after the first result
    p0 = pop_cnt;
    drive(1'b1, 32'd1, 32'd1, 1'b0);
    tick();
    drive(1'b1, 32'd2, 32'd2, 1'b0);
    tick();
    out_ready = 1'b0;
    drive(1'b1, 32'd3, 32'd3, 1'b0);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("stall_in_ready",  64'(in_ready16),  64'd0);
      chk("stall_out_valid", 64'(out_valid16), 64'd1);
      chk("stall_sum",       64'(sum16),       64'h0002);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("resume_in_ready", 64'(in_ready16), 64'd1);
    tick();
    drive(1'b1, 32'd4, 32'd4, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    repeat (4) tick();
    chk("b2b_count", 64'(pop_cnt - p0), 64'd4);
    chk("b2b_empty", 64'(q.size()),     64'd0);

    // Reset with two beats in flight, downstream stalled (reset wins)
    drive(1'b1, 32'd7, 32'd7, 1'b0);
    tick();
    drive(1'b1, 32'd8, 32'd8, 1'b0);
    tick();
    rst = 1'b1;
    out_ready = 1'b0;
    drive(1'b1, 32'd9, 32'd9, 1'b0);
    tick();
    chk("flush_out_valid", 64'(out_valid16), 64'd0);
    chk("flush_in_ready",  64'(in_ready16),  64'd1);
    rst = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 32'd5, 32'd6, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    chk("post_flush_edge1", 64'(out_valid16), 64'd0);
    tick();
    chk("post_flush_valid", 64'(out_valid16), 64'd1);
    chk("post_flush_sum",   64'(sum16),       64'h000B);
    repeat (4) tick();
    chk("post_flush_empty", 64'(q.size()), 64'd0);

    // Random traffic and backpressure across all three widths
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      a32       = $urandom;
      b32       = $urandom;
      cin       = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      if (i % 16 == 0) begin
        a32 = 32'hFFFF_FFFF;
        b32 = 32'h0;
        cin = 1'b1;
      end
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();
    chk("rand_drained", 64'(q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
